// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and byte width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_loader_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_CHECK  = 3'd2,
      ST_FINISH = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/word_packer.sv
// Packs little-endian bytes into N-bit words; byte j of a word lands in bits [8j+7:8j].
// Latency: combinational word/word_done on the byte that completes a word (caller registers).
// Backpressure: none; caller only asserts byte_vld for accepted bytes.
//
// Ports: clk/reset_n clock and async active-low reset; clr clears lanes (entry to IDLE);
//        byte_vld/byte_dat accepted byte; word_dat assembled word including this byte;
//        word_done high when the current byte is the last lane of a word.
module word_packer
   import imem_loader_pkg::*;
#(
   parameter int N = 32
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr,
   input  logic              byte_vld,
   input  logic [BYTE_W-1:0] byte_dat,
   output logic [N-1:0]      word_dat,
   output logic              word_done
);

   localparam int LANES  = N / BYTE_W;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   logic [LANE_W-1:0] lane_q, lane_d;
   logic [N-1:0]      word_q, word_d;
   logic [N-1:0]      word_shift;

   // New bytes enter at the top and shift down, so after LANES bytes the
   // first byte sits in the least significant lane.
   generate
      if (LANES > 1) begin : g_multi
         assign word_shift = {byte_dat, word_q[N-1:BYTE_W]};
      end else begin : g_single
         assign word_shift = byte_dat;
      end
   endgenerate

   always_comb begin
      word_d = word_q;
      lane_d = lane_q;
      if (clr) begin
         word_d = '0;
         lane_d = '0;
      end else if (byte_vld) begin
         word_d = word_shift;
         lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_q <= '0;
         lane_q <= '0;
      end else begin
         word_q <= word_d;
         lane_q <= lane_d;
      end
   end

   assign word_dat  = word_shift;
   assign word_done = byte_vld && !clr && (lane_q == LAST_LANE);

endmodule

// File: rtl/imem_loader.sv
// Loads instruction RAM from a length-prefixed byte stream and holds the core in reset until done.
// Latency: word write strobe one cycle after the completing byte; done two cycles after the last byte.
// Backpressure: rx_ready decoded from state only (high in IDLE/LOAD/CHECK), never from rx_valid.
//
// Ports: clk, reset_n (async active-low); rx_data/rx_valid/rx_ready byte channel;
//        reload restarts a load from DONE; we/waddr/wdata instruction RAM write port;
//        loading/done/err status; cpu_reset_n core reset release.
// Optional: define IMEM_LOADER_CHECKSUM_EN to add a trailing checksum byte and CHECK state.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int N      = 32,
   parameter int ADDR_W = 6
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              reload,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [N-1:0]      wdata,
   output logic              loading,
   output logic              done,
   output logic              err,
   output logic              cpu_reset_n
);

   localparam int DEPTH = 2**ADDR_W;
   // One extra bit so a count of DEPTH is representable.
   localparam int CNT_W = ADDR_W + 1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  widx_q, widx_d;
   logic [CNT_W-1:0]  widx_nxt;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [N-1:0]      wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              cpu_rst_n_q, cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
   logic [7:0]        chk_total;
`endif

   logic              accept;
   logic              count_bad;
   logic              pk_clr;
   logic              pk_vld;
   logic [N-1:0]      pk_word;
   logic              pk_done;

   assign rx_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
   assign loading   = (state_q != ST_DONE);
   assign accept    = rx_valid && rx_ready;
   assign count_bad = (rx_data == 8'h00) || ({1'b0, rx_data} > 9'(DEPTH));
   assign widx_nxt  = widx_q + CNT_W'(1);
   assign pk_vld    = accept && (state_q == ST_LOAD);
   // Packer lanes clear on the reload transition back into IDLE.
   assign pk_clr    = (state_q == ST_DONE) && reload;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign chk_total = sum_q + rx_data;
`endif

   word_packer #(.N(N)) u_word_packer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr       (pk_clr),
      .byte_vld  (pk_vld),
      .byte_dat  (rx_data),
      .word_dat  (pk_word),
      .word_done (pk_done)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      widx_d  = widx_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (count_bad) begin
                  err_d   = 1'b1;
                  state_d = ST_FINISH;
               end else begin
                  cnt_d   = CNT_W'(rx_data);
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d = sum_q + rx_data;
`endif
               if (pk_done) begin
                  we_d    = 1'b1;
                  waddr_d = widx_q[ADDR_W-1:0];
                  wdata_d = pk_word;
                  widx_d  = widx_nxt;
                  if (widx_nxt == cnt_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_d = ST_CHECK;
`else
                     state_d = ST_FINISH;
`endif
                  end
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (accept) begin
               if (chk_total != 8'h00) begin
                  err_d = 1'b1;
               end
               state_d = ST_FINISH;
            end
         end
`endif
         ST_FINISH: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (reload) begin
               state_d = ST_IDLE;
               err_d   = 1'b0;
               cnt_d   = '0;
               widx_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Registered from next state so done/cpu_reset_n track DONE exactly.
      done_d      = (state_d == ST_DONE);
      cpu_rst_n_d = (state_d == ST_DONE) && !err_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         widx_q      <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cpu_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         widx_q      <= widx_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cpu_rst_n_q <= cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign we          = we_q;
   assign waddr       = waddr_q;
   assign wdata       = wdata_q;
   assign done        = done_q;
   assign err         = err_q;
   assign cpu_reset_n = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams programs, logs write strobes, checks against hand values.
// Latency: n/a (testbench).
// Backpressure: byte sender waits on rx_ready with a bounded cycle budget.
module tb_imem_loader;

   logic        clk;
   logic        reset_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        reload;
   logic        we;
   logic [5:0]  waddr;
   logic [31:0] wdata;
   logic        loading;
   logic        done;
   logic        err;
   logic        cpu_reset_n;

   int n_tests = 0;
   int n_fail  = 0;

   // Write-strobe log, filled at the falling edge.
   logic [5:0]  wa_log [0:127];
   logic [31:0] wd_log [0:127];
   int          n_we = 0;

   imem_loader #(.N(32), .ADDR_W(6)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .reload      (reload),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .loading     (loading),
      .done        (done),
      .err         (err),
      .cpu_reset_n (cpu_reset_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (we) begin
         if (n_we < 128) begin
            wa_log[n_we] = waddr;
            wd_log[n_we] = wdata;
         end
         n_we = n_we + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Offer one byte; returns 1ns after the edge that accepted it.
   task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      while (!rx_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!rx_ready) check("send_ready_timeout", {63'd0, rx_ready}, 64'd1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called 1ns after the final accepted byte: FINISH now, DONE after the next edge.
   task automatic finish_chk(input string tag, input logic exp_we, input logic exp_err);
      check({tag, "_fin_ready"}, {63'd0, rx_ready}, 64'd0);
      check({tag, "_fin_we"},    {63'd0, we},       {63'd0, exp_we});
      check({tag, "_fin_done"},  {63'd0, done},     64'd0);
      @(posedge clk);
      #1;
      check({tag, "_done"},   {63'd0, done},        64'd1);
      check({tag, "_err"},    {63'd0, err},         {63'd0, exp_err});
      check({tag, "_cpurst"}, {63'd0, cpu_reset_n}, {63'd0, ~exp_err});
      check({tag, "_load"},   {63'd0, loading},     64'd0);
   endtask

   task automatic do_reload(input string tag);
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
      check({tag, "_rl_done"},   {63'd0, done},        64'd0);
      check({tag, "_rl_err"},    {63'd0, err},         64'd0);
      check({tag, "_rl_cpurst"}, {63'd0, cpu_reset_n}, 64'd0);
      check({tag, "_rl_ready"},  {63'd0, rx_ready},    64'd1);
   endtask

   task automatic reset_vals(input string tag);
      check({tag, "_ready"},  {63'd0, rx_ready},    64'd1);
      check({tag, "_we"},     {63'd0, we},          64'd0);
      check({tag, "_waddr"},  {58'd0, waddr},       64'd0);
      check({tag, "_wdata"},  {32'd0, wdata},       64'd0);
      check({tag, "_load"},   {63'd0, loading},     64'd1);
      check({tag, "_done"},   {63'd0, done},        64'd0);
      check({tag, "_err"},    {63'd0, err},         64'd0);
      check({tag, "_cpurst"}, {63'd0, cpu_reset_n}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] prog_a [0:7];
      logic [31:0] exp_w;
      int base;

      prog_a[0] = 8'h00; prog_a[1] = 8'h00; prog_a[2] = 8'h00; prog_a[3] = 8'hF8;
      prog_a[4] = 8'h01; prog_a[5] = 8'h80; prog_a[6] = 8'h00; prog_a[7] = 8'hF8;

      reset_n  = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      reload   = 1'b0;
      #1;
      reset_vals("rst");
      idle(2);
      @(negedge clk);
      reset_n = 1'b1;
      idle(1);

      // Two words, back-to-back.
      base = n_we;
      send(8'h02);
      for (int i = 0; i < 8; i++) send(prog_a[i]);
      finish_chk("a", 1'b1, 1'b0);
      check("a_nwe",    64'(n_we - base), 64'd2);
      check("a_wa0",    {58'd0, wa_log[base]},   64'd0);
      check("a_wd0",    {32'd0, wd_log[base]},   64'hF8000000);
      check("a_wa1",    {58'd0, wa_log[base+1]}, 64'd1);
      check("a_wd1",    {32'd0, wd_log[base+1]}, 64'hF8008001);
      // Bytes offered in DONE are refused and cause no writes.
      rx_valid = 1'b1;
      rx_data  = 8'hAA;
      idle(3);
      rx_valid = 1'b0;
      check("a_done_hold", {63'd0, done}, 64'd1);
      check("a_done_nwe",  64'(n_we - base), 64'd2);

      // Same program with 3-cycle gaps.
      do_reload("b");
      base = n_we;
      send(8'h02);
      idle(3);
      for (int i = 0; i < 8; i++) begin
         send(prog_a[i]);
         if (i != 7) idle(3);
      end
      finish_chk("b", 1'b1, 1'b0);
      check("b_nwe", 64'(n_we - base), 64'd2);
      check("b_wa0", {58'd0, wa_log[base]},   64'd0);
      check("b_wd0", {32'd0, wd_log[base]},   64'hF8000000);
      check("b_wa1", {58'd0, wa_log[base+1]}, 64'd1);
      check("b_wd1", {32'd0, wd_log[base+1]}, 64'hF8008001);

      // Bad count 0x00.
      do_reload("c0");
      base = n_we;
      send(8'h00);
      finish_chk("c0", 1'b0, 1'b1);
      check("c0_nwe", 64'(n_we - base), 64'd0);

      // Bad count 0x41 (DEPTH+1).
      do_reload("c41");
      base = n_we;
      send(8'h41);
      finish_chk("c41", 1'b0, 1'b1);
      check("c41_nwe", 64'(n_we - base), 64'd0);

      // Recovery with a single word.
      do_reload("c1");
      base = n_we;
      send(8'h01);
      send(8'h00); send(8'h03); send(8'h1F); send(8'hD6);
      finish_chk("c1", 1'b1, 1'b0);
      check("c1_nwe", 64'(n_we - base), 64'd1);
      check("c1_wa",  {58'd0, wa_log[base]}, 64'd0);
      check("c1_wd",  {32'd0, wd_log[base]}, 64'hD61F0300);

      // Full depth: 64 words, byte value = running byte index.
      do_reload("d");
      base = n_we;
      send(8'h40);
      for (int i = 0; i < 256; i++) send(8'(i));
      finish_chk("d", 1'b1, 1'b0);
      check("d_nwe", 64'(n_we - base), 64'd64);
      for (int w = 0; w < 64; w++) begin
         exp_w = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
         check($sformatf("d_wa%0d", w), {58'd0, wa_log[base+w]}, 64'(w));
         check($sformatf("d_wd%0d", w), {32'd0, wd_log[base+w]}, {32'd0, exp_w});
      end

      // Reset in the middle of a load.
      do_reload("e");
      base = n_we;
      send(8'h02);
      for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
      check("e_part_nwe", 64'(n_we - base), 64'd1);
      reset_n = 1'b0;
      #1;
      reset_vals("e_rst");
      @(negedge clk);
      reset_n = 1'b1;
      idle(1);
      base = n_we;
      send(8'h01);
      send(8'h0B); send(8'h00); send(8'h00); send(8'h14);
      finish_chk("e", 1'b1, 1'b0);
      check("e_nwe", 64'(n_we - base), 64'd1);
      check("e_wa",  {58'd0, wa_log[base]}, 64'd0);
      check("e_wd",  {32'd0, wd_log[base]}, 64'h1400000B);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum good: 01+02+03+04+F6 = 0x100.
      do_reload("k_ok");
      base = n_we;
      send(8'h01);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'hF6);
      finish_chk("k_ok", 1'b0, 1'b0);
      check("k_ok_nwe", 64'(n_we - base), 64'd1);
      check("k_ok_wd",  {32'd0, wd_log[base]}, 64'h04030201);

      // Checksum bad: word is still written.
      do_reload("k_bad");
      base = n_we;
      send(8'h01);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h00);
      finish_chk("k_bad", 1'b0, 1'b1);
      check("k_bad_nwe", 64'(n_we - base), 64'd1);
      check("k_bad_wa",  {58'd0, wa_log[base]}, 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
